fifo_rr_drain_arbiter: RTL
==========================

Name: fifo_rr_drain_arbiter

Overview:
- Read-side scheduler that drains NUM_CH async FIFO read ports, all in the clk (read) domain, into one registered valid/ready stream.
- Grants channels round-robin with a per-grant burst limit. Drives each FIFO's ren and tags every output word with its source channel.
- Sits between a bank of async_fifo_core read ports and a single downstream consumer.
- FIFO rdata is first-word fall-through: valid whenever rempty=0. rempty updates the cycle after ren, so back-to-back pops are safe.

Parameters:
- NUM_CH, 4, number of FIFO channels (>=2).
- DATA_WIDTH, 8, FIFO data width.
- BURST_MAX, 4, max words popped per grant before rotating (>=1).
- CH_W, $clog2(NUM_CH), channel index width (derived).

Ports:
- clk  in  1  read-domain clock.
- reset  in  1  reset, asynchronous, active-high.
- ch_rempty  in  NUM_CH  per-channel FIFO rempty.
- ch_rdata  in  NUM_CH*DATA_WIDTH  per-channel FIFO rdata; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ch_enable  in  NUM_CH  per-channel arbitration enable.
- ch_ren  out  NUM_CH  per-channel FIFO ren, at most one-hot.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  output word.
- m_chan  out  CH_W  source channel of m_data.
- busy  out  1  high while state is GRANT.

Behaviour:
- Reset values: state=IDLE, cur=0, last_ptr=NUM_CH-1, burst_cnt=0, m_valid=0, m_data=0, m_chan=0. ch_ren=0 and busy=0 while reset is held.
- req[i] = ~ch_rempty[i] & ch_enable[i].
- out_free = ~m_valid | m_ready.
- pop = (state==GRANT) & req[cur] & out_free.
- ch_ren[i] = pop & (i==cur). ch_ren is combinational, with no registered delay.
- IDLE:
  - If any req, search circularly from last_ptr+1 (mod NUM_CH) and take the first channel with req set.
  - Then set cur to that channel, set burst_cnt=0, and go to GRANT.
  - Otherwise stay in IDLE.
  - There is no pop in IDLE, so each grant costs one arbitration bubble cycle.
- GRANT, on a pop:
  - Load m_data = ch_rdata[cur] and m_chan = cur, set m_valid=1, and increment burst_cnt.
  - If burst_cnt == BURST_MAX-1 at this pop: set last_ptr=cur and go to IDLE.
- GRANT, without a pop:
  - If req[cur]=0 (channel empty or disabled): set last_ptr=cur and go to IDLE.
  - If req[cur]=1 and out_free=0 (backpressure): hold state, burst_cnt and all outputs.
- Output register:
  - If m_valid & m_ready and there is no pop in the same cycle, m_valid goes to 0.
  - If m_valid & m_ready and a pop occurs in the same cycle, the new word replaces the old one. Full throughput is one word per cycle within a burst.
- Latency: a word popped at cycle t is presented on m_data/m_valid at t+1.
- m_data and m_chan are stable while m_valid=1 and m_ready=0.
- ch_enable deasserted mid-burst:
  - The gating is combinational, so there are no further pops from that channel.
  - The FSM releases the grant in the next GRANT evaluation.
  - A word already in the output register is still delivered.
- A channel that becomes non-empty during another channel's grant waits for the next IDLE search.
- Starvation bound: a requesting channel is granted within NUM_CH-1 grants.
- burst_cnt is $clog2(BURST_MAX)+1 bits wide and never exceeds BURST_MAX-1.
- With BURST_MAX=1, each grant pops exactly one word.
- Reset asserted mid-operation:
  - All state clears immediately and any output word is discarded.
  - No ch_ren is driven while reset is high.
  - After reset the first grant goes to the lowest-index requesting channel.

Test Plan:
1. Reset with all channels non-empty -> during reset m_valid=0, ch_ren=0. After release: cycle 1 IDLE, cycle 2 ch_ren=4'b0001, cycle 3 m_valid=1 with m_chan=0.
2. Each channel preloaded with 8 words, m_ready=1, BURST_MAX=4 -> output order ch0 x4, ch1 x4, ch2 x4, ch3 x4, then repeat. One bubble between bursts, 32 words total, per-channel data order preserved.
3. Only ch2 holds 2 words -> exactly 2 words with m_chan=2, then IDLE and busy=0. Writing 1 more word to ch2 re-grants ch2 and delivers it.
4. m_ready=0 for 5 cycles while m_valid=1 mid-burst -> m_data/m_chan stable and ch_ren=0 throughout. After m_ready=1 the burst resumes with no lost or duplicated words, and the burst count is still honoured.
5. ch_enable[1] cleared after the 2nd ch1 pop -> no further ch1 pops, the next grant goes to ch2, and ch1 is never granted while disabled even with data pending.
6. Reset pulsed mid-burst on ch1 -> m_valid drops immediately and ch_ren=0. After release with all channels non-empty, the first grant goes to ch0.

Source files
------------

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain scheduler: pops a bank of FWFT FIFO read ports in bursts
// into a single registered valid/ready stream tagged with the source channel.
module fifo_rr_drain_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_rempty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
    input  logic [NUM_CH-1:0]            ch_enable,
    output logic [NUM_CH-1:0]            ch_ren,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [CH_W-1:0]              m_chan,
    output logic                         busy
);

    localparam int BC_W = $clog2(BURST_MAX) + 1;
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_MAX - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state;
    logic [CH_W-1:0]         cur;
    logic [CH_W-1:0]         last_ptr;
    logic [BC_W-1:0]         burst_cnt;

    logic [NUM_CH-1:0]       req;
    logic                    any_req;
    logic                    req_cur;
    logic                    out_free;
    logic                    pop;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [CH_W-1:0]         next_ch;
    logic [CH_W-1:0]         idx_c;
    logic                    found;
    int                      idx;

    assign req      = ~ch_rempty & ch_enable;
    assign any_req  = |req;
    assign req_cur  = req[cur];
    assign out_free = ~m_valid | m_ready;
    assign pop      = (state == GRANT) & req_cur & out_free;
    assign cur_data = ch_rdata[cur*DATA_WIDTH +: DATA_WIDTH];
    assign busy     = (state == GRANT);

    // Pop strobe is combinational so the FIFO sees ren in the same cycle as the grant decision.
    always_comb begin
        ch_ren = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ren[i] = pop & (CH_W'(i) == cur);
        end
    end

    // Circular search starting just past the channel that held the last grant.
    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        idx     = 0;
        idx_c   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx   = (int'(last_ptr) + k) % NUM_CH;
            idx_c = CH_W'(idx);
            if (!found && req[idx_c]) begin
                found   = 1'b1;
                next_ch = idx_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur       <= '0;
            last_ptr  <= CH_W'(NUM_CH - 1);
            burst_cnt <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_chan    <= '0;
        end else begin
            // Output register: a pop replaces the word, an accept without pop empties it.
            if (pop) begin
                m_data  <= cur_data;
                m_chan  <= cur;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur       <= next_ch;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (pop) begin
                        if (burst_cnt == BURST_LAST) begin
                            burst_cnt <= '0;
                            last_ptr  <= cur;
                            state     <= IDLE;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else if (!req_cur) begin
                        last_ptr <= cur;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
